// File: rtl/queue_reader.sv
// rtl/queue_reader.sv - pops command messages from the queue, range-checks them and holds them for the board controller
module queue_reader #(
   parameter int coord_bits = 4,
   parameter int board_w    = 16,
   parameter int board_h    = 16,
   parameter int msg_width  = 2 + 2*coord_bits
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  q_empty,
   input  logic [msg_width-1:0]  q_data,
   output logic                  q_read_ack,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic [1:0]            cmd_op,
   output logic [coord_bits-1:0] cmd_x,
   output logic [coord_bits-1:0] cmd_y,
   input  logic                  flush,
   output logic [7:0]            err_count,
   output logic                  busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_POP  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t state, state_next;

   logic [1:0]            msg_op;
   logic [coord_bits-1:0] msg_x;
   logic [coord_bits-1:0] msg_y;
   logic                  msg_ok;
   logic                  load_cmd;
   logic                  count_err;

   assign msg_op = q_data[msg_width-1 -: 2];
   assign msg_x  = q_data[2*coord_bits-1 -: coord_bits];
   assign msg_y  = q_data[coord_bits-1:0];

   // Coordinates are zero-extended so the board bounds compare as plain unsigned numbers.
   assign msg_ok = (msg_op != 2'd3)
                && ({{(32-coord_bits){1'b0}}, msg_x} < $unsigned(board_w))
                && ({{(32-coord_bits){1'b0}}, msg_y} < $unsigned(board_h));

   always_comb begin
      state_next = state;
      load_cmd   = 1'b0;
      count_err  = 1'b0;
      case (state)
         S_IDLE: if (!q_empty) state_next = S_POP;
         S_POP:  state_next = S_WAIT;
         S_WAIT: begin
            if (msg_ok) begin
               state_next = S_HOLD;
               load_cmd   = !flush;
            end else begin
               state_next = S_IDLE;
               count_err  = !flush;
            end
         end
         S_HOLD: if (cmd_ready) state_next = q_empty ? S_IDLE : S_POP;
         default: state_next = S_IDLE;
      endcase
      // Abort wins over every transition, including a simultaneous accept in HOLD.
      if (flush) state_next = S_IDLE;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         cmd_op    <= '0;
         cmd_x     <= '0;
         cmd_y     <= '0;
         err_count <= '0;
      end else begin
         state <= state_next;
         if (load_cmd) begin
            cmd_op <= msg_op;
            cmd_x  <= msg_x;
            cmd_y  <= msg_y;
         end
         if (count_err && (err_count != 8'hff)) err_count <= err_count + 8'd1;
      end
   end

   assign q_read_ack = (state == S_POP);
   assign cmd_valid  = (state == S_HOLD);
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_queue_reader.sv
// tb/tb_queue_reader.sv - directed self-checking bench for queue_reader
module tb_queue_reader;

   localparam int CB = 4;
   localparam int MW = 2 + 2*CB;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          q_empty;
   logic [MW-1:0] q_data;
   logic          q_read_ack;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [CB-1:0] cmd_x;
   logic [CB-1:0] cmd_y;
   logic          flush;
   logic [7:0]    err_count;
   logic          busy;

   int vectors     = 0;
   int miscompares = 0;
   int ack_count   = 0;
   logic [MW-1:0] mq[$];

   queue_reader #(.coord_bits(CB), .board_w(10), .board_h(16)) dut (
      .clock(clock), .reset_n(reset_n), .q_empty(q_empty), .q_data(q_data),
      .q_read_ack(q_read_ack), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_x(cmd_x), .cmd_y(cmd_y), .flush(flush),
      .err_count(err_count), .busy(busy)
   );

   always #5 clock = ~clock;

   function automatic logic [MW-1:0] msg(input int op, input int x, input int y);
      return {op[1:0], x[CB-1:0], y[CB-1:0]};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Queue model: a pop seen in POP delivers the head entry, valid through the following WAIT cycle.
   task automatic tick();
      @(posedge clock);
      #1;
      if (q_read_ack) begin
         ack_count++;
         if (mq.size() > 0) q_data = mq.pop_front();
      end
      q_empty = (mq.size() == 0);
   endtask

   task automatic push(input logic [MW-1:0] m);
      mq.push_back(m);
      q_empty = 1'b0;
   endtask

   // {cmd_valid, q_read_ack, busy, cmd_op, cmd_x, cmd_y}
   function automatic logic [31:0] outs();
      return {19'd0, cmd_valid, q_read_ack, busy, cmd_op, cmd_x, cmd_y};
   endfunction

   function automatic logic [31:0] exp_outs(input int v, input int a, input int b,
                                            input int op, input int x, input int y);
      return {19'd0, v[0], a[0], b[0], op[1:0], x[CB-1:0], y[CB-1:0]};
   endfunction

   initial begin
      reset_n   = 1'b0;
      q_empty   = 1'b1;
      q_data    = '0;
      cmd_ready = 1'b0;
      flush     = 1'b0;
      tick();
      check("reset_outs", outs(), exp_outs(0, 0, 0, 0, 0, 0));
      check("reset_err", {24'd0, err_count}, 32'd0);
      reset_n = 1'b1;
      tick();
      check("idle_after_reset", outs(), exp_outs(0, 0, 0, 0, 0, 0));

      // Basic latency: pop, wait, hold.
      ack_count = 0;
      push(msg(1, 3, 7));
      tick();
      check("lat_pop", outs(), exp_outs(0, 1, 1, 0, 0, 0));
      tick();
      check("lat_wait", outs(), exp_outs(0, 0, 1, 0, 0, 0));
      tick();
      check("lat_hold", outs(), exp_outs(1, 0, 1, 1, 3, 7));
      check("single_pulse", ack_count, 32'd1);

      // Backpressure with a second message waiting.
      push(msg(2, 9, 0));
      for (int i = 0; i < 5; i++) begin
         tick();
         check("backpressure_hold", outs(), exp_outs(1, 0, 1, 1, 3, 7));
      end
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("accept_then_pop", outs(), exp_outs(0, 1, 1, 1, 3, 7));
      tick();
      tick();
      check("second_cmd", outs(), exp_outs(1, 0, 1, 2, 9, 0));
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("accept_to_idle", outs(), exp_outs(0, 0, 0, 2, 9, 0));

      // Malformed: op 3, x 12, x 10 (first illegal column); then x 9, y 15 (largest legal).
      push(msg(3, 1, 1));
      push(msg(0, 12, 2));
      push(msg(0, 10, 0));
      push(msg(0, 9, 15));
      tick(); tick(); tick();
      check("drop1_err", {24'd0, err_count}, 32'd1);
      check("drop1_idle", outs(), exp_outs(0, 0, 0, 2, 9, 0));
      tick(); tick(); tick();
      tick(); tick(); tick();
      check("drop3_err", {24'd0, err_count}, 32'd3);
      tick(); tick(); tick();
      check("edge_legal_cmd", outs(), exp_outs(1, 0, 1, 0, 9, 15));
      check("edge_legal_err", {24'd0, err_count}, 32'd3);
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;

      // Flush in WAIT drops an invalid message without counting it.
      push(msg(3, 0, 0));
      tick(); tick();
      check("in_wait", outs(), exp_outs(0, 0, 1, 0, 9, 15));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_wait_idle", outs(), exp_outs(0, 0, 0, 0, 9, 15));
      check("flush_wait_err", {24'd0, err_count}, 32'd3);
      tick();
      check("flush_wait_stay", outs(), exp_outs(0, 0, 0, 0, 9, 15));

      // Flush together with cmd_ready in HOLD: not accepted, IDLE instead of POP.
      push(msg(1, 2, 2));
      push(msg(2, 4, 4));
      tick(); tick(); tick();
      check("hold_before_flush", outs(), exp_outs(1, 0, 1, 1, 2, 2));
      flush = 1'b1;
      cmd_ready = 1'b1;
      tick();
      flush = 1'b0;
      cmd_ready = 1'b0;
      check("flush_hold_idle", outs(), exp_outs(0, 0, 0, 1, 2, 2));
      check("flush_hold_err", {24'd0, err_count}, 32'd3);
      tick();
      check("restart_pop", outs(), exp_outs(0, 1, 1, 1, 2, 2));
      tick(); tick();
      check("restart_hold", outs(), exp_outs(1, 0, 1, 2, 4, 4));

      // Flush in POP: pulse already issued, popped data ignored.
      push(msg(0, 5, 5));
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;
      check("pop_before_flush", outs(), exp_outs(0, 1, 1, 2, 4, 4));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_pop_idle", outs(), exp_outs(0, 0, 0, 2, 4, 4));
      tick(); tick();
      check("flush_pop_stay", outs(), exp_outs(0, 0, 0, 2, 4, 4));

      // Asynchronous reset in the middle of a HOLD cycle.
      push(msg(1, 6, 6));
      tick(); tick(); tick();
      check("hold_before_reset", outs(), exp_outs(1, 0, 1, 1, 6, 6));
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_outs", outs(), exp_outs(0, 0, 0, 0, 0, 0));
      check("async_reset_err", {24'd0, err_count}, 32'd0);
      #2;
      reset_n = 1'b1;
      tick();
      check("post_reset_idle", outs(), exp_outs(0, 0, 0, 0, 0, 0));
      push(msg(2, 1, 2));
      tick();
      check("post_reset_pop", outs(), exp_outs(0, 1, 1, 0, 0, 0));
      tick(); tick();
      check("post_reset_hold", outs(), exp_outs(1, 0, 1, 2, 1, 2));
      cmd_ready = 1'b1;
      tick();
      cmd_ready = 1'b0;

      // Saturation: 300 malformed messages from a zero count.
      for (int i = 0; i < 300; i++) push(msg(3, 0, 0));
      for (int i = 0; i < 762; i++) tick();
      check("sat_254", {24'd0, err_count}, 32'd254);
      tick(); tick(); tick();
      check("sat_255", {24'd0, err_count}, 32'd255);
      for (int i = 0; i < 135; i++) tick();
      check("sat_hold", {24'd0, err_count}, 32'd255);
      check("sat_idle", outs(), exp_outs(0, 0, 0, 2, 1, 2));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
